// File: rtl/ram_req_ctrl_if.sv
// Request/response handshake bundle between a master and the RAM request controller.
// The master issues reads and writes; the controller returns read data in order.
interface ram_req_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 6
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ram_req_ctrl.sv
// Valid/ready front end for a single-port sync RAM with registered dout.
// Reads are credited against a small response FIFO so a captured dout always has a slot.
module ram_req_ctrl #(
  parameter int DW        = 8,
  parameter int AW        = 6,
  parameter int RSP_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  ram_req_ctrl_if.slave bus,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_V = (CW+1)'(RSP_DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(RSP_DEPTH - 1);

  logic [DW-1:0] mem [RSP_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   used;
  logic          rd_pend;
  logic          accept, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PW'(1);
  endfunction

  // An in-flight read owns a FIFO slot already, so it counts against credit.
  assign used          = {1'b0, fifo_cnt} + {{CW{1'b0}}, rd_pend};
  assign bus.req_ready = ~rst & (used < DEPTH_V);

  assign accept   = bus.req_valid & bus.req_ready;
  assign ram_we   = accept & bus.req_we;
  assign ram_addr = bus.req_addr;
  assign ram_din  = bus.req_wdata;

  assign push = rd_pend;
  assign pop  = bus.rsp_valid & bus.rsp_ready;

  assign bus.rsp_valid = (fifo_cnt != '0);
  assign bus.rsp_rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      rd_pend <= accept & ~bus.req_we;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Payload storage needs no reset; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= ram_dout;
  end
endmodule

// File: tb/tb_ram_req_ctrl.sv
// Bench for ram_req_ctrl with a behavioural 64x8 RAM; expected read data is queued at
// accept time and a negedge monitor compares every response against the queue head.
module tb_ram_req_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ram_we;
  logic [5:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic [7:0] ram [64];
  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  ram_req_ctrl_if #(.DW(8), .AW(6)) bus ();

  ram_req_ctrl #(.DW(8), .AW(6), .RSP_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // RAM: write-priority, registered dout, cleared by reset
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= 8'h00;
      ram_dout <= 8'h00;
    end else if (ram_we) begin
      ram[ram_addr] <= ram_din;
      ram_dout      <= ram_din;
    end else begin
      ram_dout <= ram[ram_addr];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ram_we", ram_we, ~rst & bus.req_valid & bus.req_we & bus.req_ready);
    if (ram_we) begin
      chk("ram_addr", ram_addr, bus.req_addr);
      chk("ram_din", ram_din, bus.req_wdata);
    end
    if (!rst && bus.rsp_valid) begin
      if (exp_q.size() == 0)  chk("unexpected_rsp", bus.rsp_rdata, -1);
      else if (bus.rsp_ready) chk("rsp_rdata", bus.rsp_rdata, exp_q.pop_front());
      else                    chk("rsp_hold", bus.rsp_rdata, exp_q[0]);
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic we, input logic [5:0] a, input logic [7:0] d, input logic [7:0] e);
    int t = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(negedge clk);
    while (!bus.req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) chk("accept_timeout", 0, 1);
    else if (!we) exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.rsp_ready = 1'b1;
    // a write presented during reset must not reach the RAM
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 6'd0;
    bus.req_wdata = 8'h77;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_ram_we", ram_we, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", bus.req_ready, 1);
    @(posedge clk);
    #1;

    // 1: write then read, 2-cycle latency
    send(1'b1, 6'd5, 8'hA5, 8'h00);
    send(1'b0, 6'd5, 8'h00, 8'hA5);
    @(negedge clk);
    chk("t1_lat_n1", bus.rsp_valid, 0);
    @(negedge clk);
    chk("t1_lat_n2", bus.rsp_valid, 1);
    @(posedge clk);
    #1;
    drain();

    // 2: credit limit with backpressure
    send(1'b1, 6'd1, 8'h11, 8'h00);
    send(1'b1, 6'd2, 8'h22, 8'h00);
    send(1'b1, 6'd3, 8'h33, 8'h00);
    bus.rsp_ready = 1'b0;
    fork
      begin
        send(1'b0, 6'd1, 8'h00, 8'h11);
        send(1'b0, 6'd2, 8'h00, 8'h22);
        send(1'b0, 6'd3, 8'h00, 8'h33);
      end
      begin
        repeat (4) @(negedge clk);
        chk("t2_credit_full", bus.req_ready, 0);
        chk("t2_accepted", exp_q.size(), 2);
        chk("t2_head", bus.rsp_rdata, 8'h11);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
      end
    join
    drain();

    // 3: top address, read-after-write, untouched address
    send(1'b1, 6'd63, 8'hFF, 8'h00);
    send(1'b0, 6'd63, 8'h00, 8'hFF);
    send(1'b0, 6'd0,  8'h00, 8'h00);
    drain();

    // 4: 20 streamed reads, pointers wrap many times
    for (int i = 0; i < 20; i++) send(1'b1, 6'(8 + i), 8'(i * 7 + 3), 8'h00);
    for (int i = 0; i < 20; i++) send(1'b0, 6'(8 + i), 8'h00, 8'(i * 7 + 3));
    drain();

    // 6: write held off by zero credit must not write
    bus.rsp_ready = 1'b0;
    send(1'b0, 6'd1, 8'h00, 8'h11);
    send(1'b0, 6'd2, 8'h00, 8'h22);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 6'd1;
    bus.req_wdata = 8'hEE;
    repeat (2) begin
      @(negedge clk);
      chk("t6_ready", bus.req_ready, 0);
      chk("t6_ram_we", ram_we, 0);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    drain();
    send(1'b0, 6'd1, 8'h00, 8'h11);
    drain();

    // 5: reset with one queued response and one read in flight
    bus.rsp_ready = 1'b0;
    send(1'b0, 6'd5, 8'h00, 8'hA5);
    send(1'b0, 6'd6, 8'h00, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_ready", bus.req_ready, 0);
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    chk("t5_rsp_flushed", bus.rsp_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t5_no_stale", bus.rsp_valid, 0);
    chk("t5_ready_back", bus.req_ready, 1);
    @(posedge clk);
    #1;
    send(1'b0, 6'd5, 8'h00, 8'h00);
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
